// File: rtl/b12_tone_decoder_pkg.sv
// ---------------------------------------------------------------------------
// b12_tone_decoder_pkg
//   Shared b12 definitions used by the tone decoder:
//   - sound codes as reported on the decoder's tone output
//   - tone-period constants as used by the b12 controller's sound generator
//   - tone_half_period(): maps a tone constant to the half-period in clocks
//   - classify_half_period(): maps a measured half-period to a sound code
//   - decoder state type
// ---------------------------------------------------------------------------
package b12_tone_decoder_pkg;

  // Sound codes.
  localparam logic [2:0] RED    = 3'd0;
  localparam logic [2:0] GREEN  = 3'd1;
  localparam logic [2:0] YELLOW = 3'd2;
  localparam logic [2:0] BLUE   = 3'd3;
  localparam logic [2:0] S_WIN  = 3'd4;
  localparam logic [2:0] S_LOSS = 3'd5;

  // Tone-period constants. The speaker toggles every T+2 clocks.
  localparam logic [3:0] ERROR_TONE  = 4'd1;
  localparam logic [3:0] RED_TONE    = 4'd2;
  localparam logic [3:0] GREEN_TONE  = 4'd3;
  localparam logic [3:0] YELLOW_TONE = 4'd4;
  localparam logic [3:0] BLUE_TONE   = 4'd5;
  localparam logic [3:0] WIN_TONE    = 4'd6;

  // Widths of the interval counter and of the captured half-period.
  // H = len+1 can reach 32, hence one bit more than the counter.
  localparam int          LEN_W   = 5;
  localparam int          HALF_W  = 6;
  localparam logic [4:0]  LEN_MAX = 5'd31;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
  } tone_class_t;

  function automatic logic [HALF_W-1:0] tone_half_period(input logic [3:0] t);
    return HALF_W'(t) + HALF_W'(2);
  endfunction

  function automatic tone_class_t classify_half_period(input logic [HALF_W-1:0] h);
    tone_class_t c;
    c.valid = 1'b1;
    c.code  = RED;
    if (h == tone_half_period(ERROR_TONE))       c.code = S_LOSS;
    else if (h == tone_half_period(RED_TONE))    c.code = RED;
    else if (h == tone_half_period(GREEN_TONE))  c.code = GREEN;
    else if (h == tone_half_period(YELLOW_TONE)) c.code = YELLOW;
    else if (h == tone_half_period(BLUE_TONE))   c.code = BLUE;
    else if (h == tone_half_period(WIN_TONE))    c.code = S_WIN;
    else                                         c.valid = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/b12_halfperiod_meter.sv
// ---------------------------------------------------------------------------
// b12_halfperiod_meter
//   Measures the interval between transitions of the b12 speaker signal.
//   Ports:
//     clk_i       clock, rising edge
//     rst_i       asynchronous active-high reset
//     speaker_i   square wave, synchronous to clk_i
//     edge_o      speaker changed this cycle (speaker_i ^ registered copy)
//     half_o      half-period ending at this edge, H = len+1
//     timeout_o   no edge this cycle and len has reached SILENCE
// ---------------------------------------------------------------------------
module b12_halfperiod_meter
  import b12_tone_decoder_pkg::*;
#(
  parameter int SILENCE = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              speaker_i,
  output logic              edge_o,
  output logic [HALF_W-1:0] half_o,
  output logic              timeout_o
);

  logic             speaker_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;

  assign edge_o    = speaker_i ^ speaker_q;
  assign half_o    = HALF_W'(len_q) + HALF_W'(1);
  // An edge always takes priority over the silence timeout.
  assign timeout_o = !edge_o && (len_q == LEN_W'(SILENCE));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    len_d = len_q;
    if (edge_o)
      len_d = '0;
    else if (len_q != LEN_MAX)
      len_d = len_q + LEN_W'(1);   // saturate at 31, never wrap
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      speaker_q <= 1'b0;
      len_q     <= '0;
    end else begin
      speaker_q <= speaker_i;
      len_q     <= len_d;
    end
  end

endmodule

// File: rtl/b12_tone_decoder.sv
// ---------------------------------------------------------------------------
// b12_tone_decoder
//   Listens to the b12 controller's speaker output and reports stable tones
//   as symbolic events.
//   Parameters:
//     CONFIRM     consecutive matching half-periods needed to lock (1..7)
//     SILENCE     edge-free cycles that declare silence (9..31)
//   Ports:
//     clock       clock, rising edge
//     reset       asynchronous active-high reset
//     speaker     square wave from b12
//     tone        locked sound code (valid only while tone_valid)
//     tone_valid  a tone is currently locked
//     tone_start  one-cycle pulse on lock acquired
//     tone_end    one-cycle pulse on lock lost
//     err         one-cycle pulse on an unrecognised half-period
//     tone_count  locks acquired since reset, wraps at 255
//   All outputs are registered: responses appear the cycle after the edge
//   or timeout cycle that caused them.
// ---------------------------------------------------------------------------
module b12_tone_decoder
  import b12_tone_decoder_pkg::*;
#(
  parameter int CONFIRM = 2,
  parameter int SILENCE = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       speaker,
  output logic [2:0] tone,
  output logic       tone_valid,
  output logic       tone_start,
  output logic       tone_end,
  output logic       err,
  output logic [7:0] tone_count
);

  localparam logic [2:0] CONFIRM_C = 3'(CONFIRM);

  logic              hp_edge;
  logic [HALF_W-1:0] hp_half;
  logic              hp_timeout;
  tone_class_t       hp_class;

  dec_state_e state_q, state_d;
  logic [2:0] cand_q,  cand_d;
  logic [2:0] cnt_q,   cnt_d;
  logic [2:0] tone_q,  tone_d;
  logic       valid_q, valid_d;
  logic       start_q, start_d;
  logic       end_q,   end_d;
  logic       err_q,   err_d;
  logic [7:0] count_q, count_d;

  logic       do_lock;
  logic [2:0] lock_code;

  b12_halfperiod_meter #(
    .SILENCE (SILENCE)
  ) u_meter (
    .clk_i     (clock),
    .rst_i     (reset),
    .speaker_i (speaker),
    .edge_o    (hp_edge),
    .half_o    (hp_half),
    .timeout_o (hp_timeout)
  );

  assign hp_class = classify_half_period(hp_half);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SILENT;
      cand_q  <= '0;
      cnt_q   <= '0;
      tone_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
      valid_q <= valid_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    tone_d    = tone_q;
    valid_d   = valid_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    count_d   = count_q;
    do_lock   = 1'b0;
    lock_code = cand_q;

    if (hp_edge) begin
      unique case (state_q)
        SILENT: begin
          // The interval before the first edge is the idle gap, not a tone.
          state_d = ACQUIRE;
          cnt_d   = '0;
        end

        ACQUIRE: begin
          if (hp_class.valid) begin
            if (hp_class.code == cand_q && cnt_q != 3'd0) begin
              cnt_d = cnt_q + 3'd1;
            end else begin
              cand_d = hp_class.code;
              cnt_d  = 3'd1;
            end
            if (cnt_d == CONFIRM_C) begin
              do_lock   = 1'b1;
              lock_code = cand_d;
            end
          end else begin
            err_d = 1'b1;
            cnt_d = '0;
          end
        end

        LOCKED: begin
          if (hp_class.valid && hp_class.code != tone_q) begin
            end_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ACQUIRE;
            cand_d  = hp_class.code;
            cnt_d   = 3'd1;
            // With CONFIRM=1 the new tone relocks in the same update.
            if (CONFIRM_C == 3'd1) begin
              do_lock   = 1'b1;
              lock_code = hp_class.code;
            end
          end else if (!hp_class.valid) begin
            err_d   = 1'b1;
            end_d   = 1'b1;
            valid_d = 1'b0;
            state_d = ACQUIRE;
            cnt_d   = '0;
          end
        end

        default: state_d = SILENT;
      endcase
    end else if (hp_timeout) begin
      state_d = SILENT;
      if (state_q == LOCKED) begin
        end_d   = 1'b1;
        valid_d = 1'b0;
      end
    end

    if (do_lock) begin
      state_d = LOCKED;
      tone_d  = lock_code;
      valid_d = 1'b1;
      start_d = 1'b1;
      count_d = count_q + 8'd1;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    tone       = tone_q;
    tone_valid = valid_q;
    tone_start = start_q;
    tone_end   = end_q;
    err        = err_q;
    tone_count = count_q;
  end

endmodule
